// File: rtl/p2s_pkg.sv
// Shared constants, FSM state type and bit-rate helper for the 4-lane
// parallel-to-serial sequencing controller.
package p2s_pkg;

  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int LANE_W = WORD_W / LANES;
  localparam int RATE_W = 2;
  localparam int DIV_W  = 3;
  localparam int CNT_W  = 16;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    SHIFT
  } state_t;

  // Terminal count of the bit-period divider: 2^rate - 1.
  function automatic logic [DIV_W-1:0] rate_mask(input logic [RATE_W-1:0] rate);
    return DIV_W'((4'd1 << rate) - 4'd1);
  endfunction

endpackage

// File: rtl/p2s_rate_div.sv
// Bit-period divider: counts 0..2^rate_q-1 while enabled and pulses tc on the
// last cycle of each bit period.
module p2s_rate_div
  import p2s_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [RATE_W-1:0] rate_q,
  input  logic              clr,
  input  logic              en,
  output logic              tc
);

  logic [DIV_W-1:0] div_reg;

  assign tc = en && (div_reg == rate_mask(rate_q));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_reg <= '0;
    end else if (clr) begin
      div_reg <= '0;
    end else if (en) begin
      div_reg <= tc ? '0 : div_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/p2s_ctrl.sv
// Sequencing controller for the parallel-to-serial datapath: one-word pending
// buffer, load strobe generation and MSB-first bit stepping at 2^rate cycles/bit.
module p2s_ctrl #(
  parameter int WORD_W = p2s_pkg::WORD_W,
  parameter int LANES  = p2s_pkg::LANES,
  parameter int LANE_W = WORD_W / LANES,
  parameter int SEL_W  = $clog2(LANE_W)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enb,
  input  logic [1:0]        rate,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              ld,
  output logic [WORD_W-1:0] d,
  output logic [SEL_W-1:0]  bit_sel,
  output logic              out_valid,
  output logic              frame,
  output logic              busy,
  output logic [15:0]       words_sent
);
  import p2s_pkg::*;

  localparam logic [SEL_W-1:0] TOP_BIT = SEL_W'(LANE_W - 1);

  state_t            state_reg, state_next;
  logic              pend_v_reg, pend_v_next;
  logic [WORD_W-1:0] pend_data_reg, pend_data_next;
  logic [1:0]        rate_reg, rate_next;
  logic [SEL_W-1:0]  bit_idx_reg, bit_idx_next;
  logic [15:0]       words_reg, words_next;
  logic              out_valid_reg, frame_reg, busy_reg;
  logic              div_clr, div_en, div_tc;

  p2s_rate_div u_rate_div (
    .clk    (clk),
    .rst_n  (rst_n),
    .rate_q (rate_reg),
    .clr    (div_clr),
    .en     (div_en),
    .tc     (div_tc)
  );

  always_comb begin
    state_next     = state_reg;
    pend_v_next    = pend_v_reg;
    pend_data_next = pend_data_reg;
    rate_next      = rate_reg;
    bit_idx_next   = bit_idx_reg;
    words_next     = words_reg;
    div_clr        = 1'b0;
    div_en         = enb && (state_reg == SHIFT);
    in_ready       = enb && !pend_v_reg;
    // A load happens either from LOAD or on the very last cycle of bit 0 when
    // a word is waiting, which is what keeps consecutive frames gapless.
    ld             = enb && ((state_reg == LOAD) ||
                             ((state_reg == SHIFT) && (bit_idx_reg == '0) &&
                              div_tc && pend_v_reg));
    if (enb) begin
      if (in_valid && in_ready) begin
        pend_v_next    = 1'b1;
        pend_data_next = in_data;
      end
      case (state_reg)
        IDLE: begin
          if (pend_v_reg) state_next = LOAD;
        end
        SHIFT: begin
          if (div_tc) begin
            if (bit_idx_reg != '0) begin
              bit_idx_next = bit_idx_reg - SEL_W'(1);
            end else begin
              words_next = words_reg + 16'd1;
              if (!pend_v_reg) state_next = IDLE;
            end
          end
        end
        default: ;
      endcase
      if (ld) begin
        pend_v_next  = 1'b0;
        rate_next    = rate;
        bit_idx_next = TOP_BIT;
        div_clr      = 1'b1;
        state_next   = SHIFT;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      pend_v_reg    <= 1'b0;
      pend_data_reg <= '0;
      rate_reg      <= '0;
      bit_idx_reg   <= '0;
      words_reg     <= '0;
      out_valid_reg <= 1'b0;
      frame_reg     <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      state_reg     <= state_next;
      pend_v_reg    <= pend_v_next;
      pend_data_reg <= pend_data_next;
      rate_reg      <= rate_next;
      bit_idx_reg   <= bit_idx_next;
      words_reg     <= words_next;
      out_valid_reg <= (state_next == SHIFT);
      frame_reg     <= (state_next == SHIFT) && (bit_idx_next == TOP_BIT);
      busy_reg      <= (state_next != IDLE) || pend_v_next;
    end
  end

  // The pending buffer doubles as the load word: it is stable during every ld.
  assign d          = pend_data_reg;
  assign bit_sel    = bit_idx_reg;
  assign out_valid  = out_valid_reg;
  assign frame      = frame_reg;
  assign busy       = busy_reg;
  assign words_sent = words_reg;

endmodule

// File: tb/tb_p2s_ctrl.sv
// Directed bench for p2s_ctrl with a per-cycle reference model and a queue of
// accepted words that is checked against d on every load strobe.
module tb_p2s_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enb;
  logic [1:0]  rate;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        ld;
  logic [31:0] d;
  logic [2:0]  bit_sel;
  logic        out_valid;
  logic        frame;
  logic        busy;
  logic [15:0] words_sent;

  int          checks = 0;
  int          errors = 0;

  logic [31:0] exp_q[$];
  int          ld_pos[$];
  int          ld_cnt;
  int          ov_run;
  int          ov_max;

  int          m_phase;
  int          m_k;
  int          m_r;
  int          m_sel;
  logic        m_pend;
  logic [15:0] m_words;

  logic [31:0] f_words[20];

  always #5 clk = ~clk;

  p2s_ctrl dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enb        (enb),
    .rate       (rate),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .ld         (ld),
    .d          (d),
    .bit_sel    (bit_sel),
    .out_valid  (out_valid),
    .frame      (frame),
    .busy       (busy),
    .words_sent (words_sent)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_stats();
    ld_cnt = 0;
    ov_max = 0;
    ld_pos.delete();
  endtask

  // Cycle model of the controller, evaluated mid-cycle on the falling edge.
  task automatic monitor();
    logic m_last, e_ld, e_rdy;
    int   e_sel;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_phase = 0; m_k = 0; m_r = 0; m_sel = 0; m_pend = 1'b0; m_words = '0;
        ov_run = 0;
        exp_q.delete();
        continue;
      end
      m_last = (m_phase == 2) && (m_k == (8 << m_r) - 1);
      e_ld   = enb && ((m_phase == 1) || (m_last && m_pend));
      e_rdy  = enb && !m_pend;
      e_sel  = (m_phase == 2) ? 7 - (m_k >> m_r) : m_sel;
      check("ld", 32'(ld), 32'(e_ld));
      check("in_ready", 32'(in_ready), 32'(e_rdy));
      check("out_valid", 32'(out_valid), 32'(m_phase == 2));
      check("bit_sel", 32'(bit_sel), 32'(e_sel));
      check("frame", 32'(frame), 32'((m_phase == 2) && (e_sel == 7)));
      check("busy", 32'(busy), 32'((m_phase != 0) || m_pend));
      check("words_sent", 32'(words_sent), 32'(m_words));
      if (out_valid) ov_run++; else ov_run = 0;
      if (ov_run > ov_max) ov_max = ov_run;
      if (ld) begin
        ld_cnt++;
        if (out_valid) ld_pos.push_back(ov_run);
        check("sb_has_word", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("d_on_ld", d, exp_q.pop_front());
      end
      if (enb) begin
        case (m_phase)
          0: if (m_pend) m_phase = 1;
          1: begin m_phase = 2; m_k = 0; m_r = int'(rate); m_pend = 1'b0; end
          default: begin
            m_sel = e_sel;
            if (m_last) begin
              m_words = m_words + 16'd1;
              if (m_pend) begin m_k = 0; m_r = int'(rate); m_pend = 1'b0; end
              else m_phase = 0;
            end else begin
              m_k++;
            end
          end
        endcase
        if (in_valid && e_rdy) begin
          m_pend = 1'b1;
          exp_q.push_back(in_data);
        end
      end
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0; in_valid = 1'b0; enb = 1'b1;
    tick();
    tick();
    check("rst_ld", 32'(ld), 32'd0);
    check("rst_d", d, 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_words", 32'(words_sent), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
  endtask

  task automatic send(input logic [31:0] w);
    int n = 0;
    in_valid = 1'b1;
    in_data  = w;
    while (!in_ready && n < 300) begin
      tick();
      n++;
    end
    check("send_wait_bounded", 32'(n < 300), 32'd1);
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || out_valid) && n < 2000) begin
      tick();
      n++;
    end
    check("idle_wait_bounded", 32'(n < 2000), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; enb = 1'b1; rate = 2'd0; in_valid = 1'b0; in_data = '0;
    clear_stats();
    fork
      monitor();
    join_none

    // Single word at rate 0: exact cycle timing.
    do_reset();
    clear_stats();
    rate = 2'd0; in_valid = 1'b1; in_data = 32'hA5C30F81;
    check("a_ready_c0", 32'(in_ready), 32'd1);
    tick();
    in_valid = 1'b0;
    check("a_ld_c1", 32'(ld), 32'd0);
    check("a_ready_c1", 32'(in_ready), 32'd0);
    check("a_busy_c1", 32'(busy), 32'd1);
    tick();
    check("a_ld_c2", 32'(ld), 32'd1);
    check("a_d_c2", d, 32'hA5C30F81);
    check("a_ov_c2", 32'(out_valid), 32'd0);
    tick();
    for (int i = 0; i < 8; i++) begin
      check("a_ov", 32'(out_valid), 32'd1);
      check("a_bit_sel", 32'(bit_sel), 32'(7 - i));
      check("a_frame", 32'(frame), 32'(i == 0));
      tick();
    end
    check("a_ov_end", 32'(out_valid), 32'd0);
    check("a_busy_end", 32'(busy), 32'd0);
    check("a_words", 32'(words_sent), 32'd1);
    check("a_ld_cnt", 32'(ld_cnt), 32'd1);

    // Two words back-to-back at rate 1.
    do_reset();
    clear_stats();
    rate = 2'd1;
    send(32'h12345678);
    send(32'h9ABCDEF0);
    wait_idle();
    check("b_ov_run", 32'(ov_max), 32'd32);
    check("b_ld_cnt", 32'(ld_cnt), 32'd2);
    check("b_gapless_cnt", 32'(ld_pos.size()), 32'd1);
    check("b_gapless_pos", 32'(ld_pos[0]), 32'd16);
    check("b_words", 32'(words_sent), 32'd2);

    // ENB low for 5 cycles during bit 4 at rate 2, second word queued.
    do_reset();
    clear_stats();
    rate = 2'd2;
    send(32'h0F1E2D3C);
    send(32'hC3D2E1F0);
    begin
      int n = 0;
      while (!(out_valid && bit_sel == 3'd4) && n < 200) begin
        tick();
        n++;
      end
      check("c_reach_bit4", 32'(n < 200), 32'd1);
    end
    enb = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      check("c_frz_ld", 32'(ld), 32'd0);
      check("c_frz_ready", 32'(in_ready), 32'd0);
      check("c_frz_bit_sel", 32'(bit_sel), 32'd4);
      tick();
    end
    enb = 1'b1;
    wait_idle();
    check("c_ov_run", 32'(ov_max), 32'd69);
    check("c_ld_cnt", 32'(ld_cnt), 32'd2);
    check("c_gapless_pos", 32'(ld_pos[0]), 32'd37);
    check("c_words", 32'(words_sent), 32'd2);

    // ENB low on the load cycle itself: the load fires once when it returns.
    do_reset();
    clear_stats();
    rate = 2'd0; in_valid = 1'b1; in_data = 32'h5A5A0FF0;
    tick();
    in_valid = 1'b0;
    tick();
    check("c2_ld_on", 32'(ld), 32'd1);
    enb = 1'b0;
    #1;
    check("c2_ld_gated", 32'(ld), 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("c2_ld_hold", 32'(ld), 32'd0);
    end
    enb = 1'b1;
    #1;
    check("c2_ld_resume", 32'(ld), 32'd1);
    check("c2_d_resume", d, 32'h5A5A0FF0);
    wait_idle();
    check("c2_ld_cnt", 32'(ld_cnt), 32'd1);
    check("c2_ov_run", 32'(ov_max), 32'd8);

    // Rate 3 latched at load, changed to 0 mid-frame.
    do_reset();
    clear_stats();
    rate = 2'd3;
    send(32'hDEADBEEF);
    send(32'h0BADF00D);
    rate = 2'd0;
    wait_idle();
    check("d_ov_run", 32'(ov_max), 32'd72);
    check("d_gapless_pos", 32'(ld_pos[0]), 32'd64);
    check("d_words", 32'(words_sent), 32'd2);

    // Asynchronous reset mid-SHIFT with a word pending.
    clear_stats();
    rate = 2'd2;
    send(32'h11112222);
    send(32'h33334444);
    tick(); tick(); tick();
    check("e_pre_ov", 32'(out_valid), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("e_rst_ld", 32'(ld), 32'd0);
    check("e_rst_d", d, 32'd0);
    check("e_rst_bit_sel", 32'(bit_sel), 32'd0);
    check("e_rst_ov", 32'(out_valid), 32'd0);
    check("e_rst_frame", 32'(frame), 32'd0);
    check("e_rst_busy", 32'(busy), 32'd0);
    check("e_rst_words", 32'(words_sent), 32'd0);
    tick();
    rst_n = 1'b1;
    clear_stats();
    for (int i = 0; i < 60; i++) tick();
    check("e_no_ld", 32'(ld_cnt), 32'd0);
    check("e_no_ov", 32'(ov_max), 32'd0);
    check("e_words", 32'(words_sent), 32'd0);

    // Twenty words with in_valid held high.
    do_reset();
    clear_stats();
    rate = 2'd0;
    for (int i = 0; i < 20; i++) f_words[i] = $urandom;
    begin
      int   idx = 0;
      int   n = 0;
      logic acc;
      in_valid = 1'b1;
      while (idx < 20 && n < 1000) begin
        in_data = f_words[idx];
        acc = in_ready;
        tick();
        if (acc) idx++;
        n++;
      end
      in_valid = 1'b0;
      check("f_all_accepted", 32'(idx), 32'd20);
    end
    wait_idle();
    check("f_words", 32'(words_sent), 32'd20);
    check("f_ld_cnt", 32'(ld_cnt), 32'd20);
    check("f_ov_run", 32'(ov_max), 32'd160);
    check("f_sb_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/p2s_ctrl.md
# p2s_ctrl

Sequencing controller for the 4-lane parallel-to-serial datapath. It accepts 32-bit words over a valid/ready handshake and holds one word in a pending buffer. It drives the datapath load strobe and load word, then steps the per-lane bit index MSB-first at a programmable bit rate. Back-to-back words serialize with no idle cycle between frames.

## Interface
Parameters:
- WORD_W, 32, input word width
- LANES, 4, serial lanes (one data_out bit each)
- LANE_W, WORD_W/LANES = 8, bits per lane per frame; bit_sel width is log2(LANE_W) = 3

Ports:
- CLK  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low
- ENB  in  1  global enable; 0 freezes the controller
- rate  in  2  bit period = 2^rate CLK cycles (1/2/4/8), latched at load
- in_valid  in  1  upstream word valid
- in_data  in  32  upstream word
- in_ready  out  1  = ENB & !pend_v (combinational)
- ld  out  1  one-cycle strobe; datapath captures D on this edge
- D  out  32  word to load into the datapath lane registers
- bit_sel  out  3  bit index of each lane presented on data_out
- out_valid  out  1  data_out meaningful this cycle
- frame  out  1  high during every cycle of bit 7 of a word
- busy  out  1  state != IDLE or pend_v
- words_sent  out  16  count of completed frames, wraps at 0xFFFF→0

## Operation
- Accept: in_valid & in_ready at an edge stores pend_q <= in_data and sets pend_v. There is a single pending slot; in_ready is low while it is full.
- FSM states: IDLE, LOAD, SHIFT.
- IDLE → LOAD when pend_v.
- LOAD (one cycle): ld=1, D=pend_q. Clears pend_v, latches rate_q <= rate, sets bit_idx=7 and div=0. Goes to SHIFT.
- SHIFT: out_valid=1, bit_sel=bit_idx. div counts 0..2^rate_q−1; at terminal count, div returns to 0 and:
  - bit_idx>0: bit_idx decrements.
  - bit_idx==0: words_sent increments. If pend_v, assert ld in this same cycle with D=pend_q, clear pend_v, relatch rate, set bit_idx=7, and stay in SHIFT (gapless). Otherwise go to IDLE.
- ENB=0: no state, counter, or buffer updates. ld and in_ready are forced 0; other outputs hold. When ENB returns, the pending ld fires exactly once.
- A rate change mid-frame has no effect until the next load.
- Reset (asynchronous, any state): state=IDLE, pend_v=0 (pending word dropped), D=0, bit_sel=0, ld=0, out_valid=0, frame=0, busy=0, words_sent=0, rate_q=0, div=0. After reset, in_ready=1 if ENB=1.

## Timing
- Accept in cycle 0 → IDLE/pend_v in cycle 1 → ld in cycle 2 → first out_valid (bit 7) in cycle 3.
- Frame length = 8·2^rate_q cycles of out_valid.
- Back-to-back: the next ld coincides with the last cycle of bit 0, so out_valid stays continuous.
- A new word can be accepted from the cycle after a ld (the pending slot is free again).
- Registered outputs (ld, D, bit_sel, out_valid, frame) reflect state in the same cycle; there is no extra pipeline stage.

## Structure
- Package p2s_pkg holds the WORD_W/LANES/LANE_W constants and the state enum (IDLE, LOAD, SHIFT).
- Sub-module p2s_rate_div is the div counter. Inputs: rate_q, clr, en. Output: terminal-count pulse.
- The pending buffer, FSM, bit counter and words_sent counter live in p2s_ctrl.

## Test plan
- Reset mid-SHIFT (async, between edges) → all outputs 0 immediately, words_sent=0. The pending word is never loaded after release.
- Single word 0xA5C30F81, rate=0 → ld in cycle 2 with D=0xA5C30F81; bit_sel 7,6,…,0 on 8 consecutive cycles; frame on the first cycle only; words_sent=1; busy drops afterwards.
- Two words 0x12345678 then 0x9ABCDEF0, rate=1 → 32 contiguous out_valid cycles. The second ld lands on the 16th out_valid cycle; words_sent=2.
- ENB=0 for 5 cycles during bit 4 at rate=2 → bit_sel holds 4, the frame stretches to 37 cycles, and each word gets exactly one ld.
- rate=3 at load, changed to 0 mid-frame → current frame is 64 cycles; the next queued word is 8 cycles.
- in_valid held high with ENB=1 and no backpressure → in_ready toggles with pend_v; no word is lost or duplicated over 20 words; words_sent=20.
